// File: rtl/exp7_exibe_sequencia_if.sv
// Control, RAM read port and display bus of the sequence-display engine.
// master = control unit / RAM / LED mux side, slave = the display engine.
interface exp7_exibe_sequencia_if;
  logic       iniciar;
  logic       cancela;
  logic [3:0] rodada;
  logic [3:0] mem_dado;
  logic [3:0] mem_endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       pronto;
  logic [2:0] db_estado;

  // Handshake: iniciar is a level sampled only while idle; cancela aborts in any
  // state and wins over everything; pronto pulses for one cycle after the last entry.
  modport master (
    output iniciar, cancela, rodada, mem_dado,
    input  mem_endereco, leds, exibindo, pronto, db_estado
  );

  modport slave (
    input  iniciar, cancela, rodada, mem_dado,
    output mem_endereco, leds, exibindo, pronto, db_estado
  );
endinterface

// File: rtl/exp7_exibe_sequencia.sv
// Plays the stored game sequence from RAM address 0 through the captured round
// index on the LEDs: each entry lit ON_CYCLES, then blanked OFF_CYCLES.
module exp7_exibe_sequencia #(
  parameter int ON_CYCLES  = 2000,
  parameter int OFF_CYCLES = 500
) (
  input  logic                   clock,
  input  logic                   reset,
  exp7_exibe_sequencia_if.slave  bus
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    BUSCA   = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } estado_t;

  estado_t       estado, estado_n;
  logic [3:0]    endereco, endereco_n;
  logic [3:0]    rodada_reg, rodada_reg_n;
  logic [3:0]    led_latch, led_latch_n;
  logic [TW-1:0] timer, timer_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      endereco   <= 4'd0;
      rodada_reg <= 4'd0;
      led_latch  <= 4'd0;
      timer      <= '0;
    end else begin
      estado     <= estado_n;
      endereco   <= endereco_n;
      rodada_reg <= rodada_reg_n;
      led_latch  <= led_latch_n;
      timer      <= timer_n;
    end
  end

  always_comb begin
    estado_n     = estado;
    endereco_n   = endereco;
    rodada_reg_n = rodada_reg;
    led_latch_n  = led_latch;
    timer_n      = timer;
    if (bus.cancela) begin
      estado_n    = OCIOSO;
      timer_n     = '0;
      led_latch_n = 4'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          timer_n = '0;
          if (bus.iniciar) begin
            endereco_n   = 4'd0;
            rodada_reg_n = bus.rodada;
            estado_n     = BUSCA;
          end
        end
        BUSCA: begin
          led_latch_n = bus.mem_dado;
          timer_n     = '0;
          estado_n    = ACESO;
        end
        ACESO: begin
          if (timer == ON_LAST) begin
            timer_n  = '0;
            estado_n = APAGADO;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        APAGADO: begin
          if (timer == OFF_LAST) begin
            timer_n = '0;
            // Stop on the last entry rather than incrementing, so the address never wraps.
            if (endereco == rodada_reg) begin
              estado_n = FIM;
            end else begin
              endereco_n = endereco + 4'd1;
              estado_n   = BUSCA;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        FIM: begin
          estado_n = OCIOSO;
        end
        default: begin
          estado_n = OCIOSO;
          timer_n  = '0;
        end
      endcase
    end
  end

  assign bus.mem_endereco = endereco;
  assign bus.leds         = (estado == ACESO) ? led_latch : 4'd0;
  assign bus.exibindo     = (estado != OCIOSO);
  assign bus.pronto       = (estado == FIM);
  assign bus.db_estado    = estado;

endmodule

// File: tb/tb_exp7_exibe_sequencia.sv
// Directed bench for the sequence-display engine with ON_CYCLES=3, OFF_CYCLES=2.
module tb_exp7_exibe_sequencia;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = 1 + ON + OFF;

  logic clock;
  logic reset;
  logic [3:0] ram [16];
  int checks;
  int errors;

  exp7_exibe_sequencia_if bus ();

  exp7_exibe_sequencia #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  assign bus.mem_dado = ram[bus.mem_endereco];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed vector: {db_estado, exibindo, pronto, mem_endereco, leds}
  function automatic logic [12:0] obs();
    return {bus.db_estado, bus.exibindo, bus.pronto, bus.mem_endereco, bus.leds};
  endfunction

  // Expected vector for cycle c after the starting edge, round index r.
  function automatic logic [12:0] exp_vec(input int c, input int r);
    int e;
    int o;
    if (c <= (r + 1) * P) begin
      e = (c - 1) / P;
      o = (c - 1) % P;
      if (o == 0)       return {3'd1, 1'b1, 1'b0, 4'(e), 4'd0};
      else if (o <= ON) return {3'd2, 1'b1, 1'b0, 4'(e), ram[e]};
      else              return {3'd3, 1'b1, 1'b0, 4'(e), 4'd0};
    end else if (c == (r + 1) * P + 1) begin
      return {3'd4, 1'b1, 1'b1, 4'(r), 4'd0};
    end
    return {3'd0, 1'b0, 1'b0, 4'(r), 4'd0};
  endfunction

  // Called at a negedge while idle; checks every cycle through the idle cycle after FIM.
  // poke>0 asserts iniciar for one cycle at that cycle to show it is ignored.
  task automatic run_sequence(input string name, input int r, input int poke);
    logic [12:0] e;
    bus.iniciar = 1'b1;
    bus.rodada  = 4'(r);
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    bus.rodada  = ~4'(r);
    for (int c = 1; c <= (r + 1) * P + 2; c++) begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      e = exp_vec(c, r);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs(), e);
      end
      if (c == poke) bus.iniciar = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.iniciar = 1'b0;
    bus.cancela = 1'b0;
    bus.rodada  = 4'd0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs(), 13'd0);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (i % 10 == 0) bus.rodada = 4'($urandom_range(0, 15));
      checks++;
      if (obs() !== 13'd0) begin
        errors++;
        $display("FAIL idle cycle %0d: got %h expected %h", i, obs(), 13'd0);
      end
    end
  endtask

  task automatic test_single();
    ram[0] = 4'b0101;
    run_sequence("single", 0, 0);
  endtask

  task automatic test_three();
    ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4;
    run_sequence("three", 2, 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) ram[i] = 4'(i);
    run_sequence("full", 15, 0);
  endtask

  task automatic test_back_to_back();
    ram[0] = 4'd9; ram[1] = 4'd0;
    run_sequence("b2b_first", 1, 0);
    run_sequence("b2b_second", 0, 0);
  endtask

  task automatic test_ignore_start();
    ram[0] = 4'd3; ram[1] = 4'd12; ram[2] = 4'd6;
    run_sequence("ignore_start", 2, 9);
  endtask

  task automatic test_cancel();
    logic [12:0] e;
    for (int i = 0; i < 16; i++) ram[i] = 4'(i);
    bus.iniciar = 1'b1;
    bus.rodada  = 4'd3;
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      e = exp_vec(c, 3);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL cancel_pre cycle %0d: got %h expected %h", c, obs(), e);
      end
    end
    bus.cancela = 1'b1;
    @(negedge clock);
    bus.cancela = 1'b0;
    e = {3'd0, 1'b0, 1'b0, 4'd1, 4'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL cancel_next: got %h expected %h", obs(), e);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL cancel_after cycle %0d: got %h expected %h", i, obs(), e);
      end
    end
    run_sequence("cancel_restart", 3, 0);
  endtask

  task automatic test_async_reset();
    logic [12:0] e;
    ram[0] = 4'd15; ram[1] = 4'd10;
    bus.iniciar = 1'b1;
    bus.rodada  = 4'd1;
    @(posedge clock);
    #1;
    bus.iniciar = 1'b0;
    repeat (5) @(negedge clock);
    e = exp_vec(5, 1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL areset_pre: got %h expected %h", obs(), e);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL areset_now: got %h expected %h", obs(), 13'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL areset_after: got %h expected %h", obs(), 13'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) ram[i] = 4'd0;
    test_reset();
    test_idle();
    test_single();
    test_three();
    test_full();
    test_back_to_back();
    test_ignore_start();
    test_cancel();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
